// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad scanner and its column strobe.
package keypad_scanner_pkg;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned COL_W = 4;
  localparam int unsigned ROW_W = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned KEY_W = 4;
  localparam int unsigned DBC_W = 4;

  localparam logic [COL_W-1:0] COL_RESET = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } state_e;

  // Outcome of one full four-column scan: exactly one key seen, or not.
  typedef struct packed {
    logic             single;
    logic [KEY_W-1:0] code;
  } scan_res_t;

  function automatic logic [KEY_W-1:0] pack_code(input logic [IDX_W-1:0] col_idx,
                                                 input logic [IDX_W-1:0] row_idx);
    return {col_idx, row_idx};
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix pins plus the decoded key outputs.
interface keypad_scanner_if;
  import keypad_scanner_pkg::*;

  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [KEY_W-1:0] key;
  logic             key_valid;
  logic             key_held;

  modport master (input row, output col, output key, output key_valid, output key_held);
  modport slave  (output row, input col, input key, input key_valid, input key_held);

endinterface

// File: rtl/keypad_scanner_scan_strobe.sv
// Dwell counter and active-low column rotation; flags the sample cycle and the end of a full scan.
module keypad_scanner_scan_strobe
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned SCAN_MAX = 65000
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [COL_W-1:0] col_o,
  output logic [IDX_W-1:0] col_idx_o,
  output logic             sample_c_o,
  output logic             scan_end_c_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] col_idx_q;
  logic [COL_W-1:0] col_q;

  assign sample_c_o   = (cnt_q == CNT_W'(SCAN_MAX));
  assign scan_end_c_o = sample_c_o && (col_idx_q == IDX_W'(3));
  assign col_o        = col_q;
  assign col_idx_o    = col_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      col_idx_q <= '0;
      col_q     <= COL_RESET;
    end else if (sample_c_o) begin
      cnt_q     <= '0;
      col_idx_q <= col_idx_q + IDX_W'(1);
      col_q     <= {col_q[COL_W-2:0], col_q[COL_W-1]};
    end else begin
      cnt_q     <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: synchronizes rows, classifies each full scan, and debounces press/release.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned SCAN_MAX       = 65000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  keypad_scanner_if.master  kp
);

  typedef logic [DBC_W:0] dbc_ext_t;
  localparam dbc_ext_t DBC_TERM = dbc_ext_t'(DEBOUNCE_SCANS);

  logic [COL_W-1:0] col_w;
  logic [IDX_W-1:0] col_idx_w;
  logic             sample_w;
  logic             scan_end_w;

  logic [ROW_W-1:0] row_meta_q;
  logic [ROW_W-1:0] row_sync_q;
  logic [1:0]       acc_cnt_q;
  logic [KEY_W-1:0] acc_code_q;

  state_e           state_q;
  logic [KEY_W-1:0] cand_q;
  logic [DBC_W-1:0] dbc_q;
  logic [KEY_W-1:0] key_q;
  logic             key_valid_q;
  logic             key_held_q;

  logic [2:0]       hits_c;
  logic [IDX_W-1:0] first_row_c;
  logic [2:0]       total_c;
  logic [1:0]       acc_cnt_d;
  logic [KEY_W-1:0] acc_code_d;
  scan_res_t        res_c;
  dbc_ext_t         dbc_inc_c;
  logic             dbc_done_c;

  keypad_scanner_scan_strobe #(
    .SCAN_MAX (SCAN_MAX)
  ) u_strobe (
    .clk          (clk),
    .rst_n        (rst_n),
    .col_o        (col_w),
    .col_idx_o    (col_idx_w),
    .sample_c_o   (sample_w),
    .scan_end_c_o (scan_end_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
    end else begin
      row_meta_q <= kp.row;
      row_sync_q <= row_meta_q;
    end
  end

  // Fold this column's sample into the running scan tally; the tally saturates at two presses.
  always_comb begin
    hits_c      = '0;
    first_row_c = '0;
    for (int r = ROW_W - 1; r >= 0; r--) begin
      if (!row_sync_q[r]) begin
        hits_c      = hits_c + 3'd1;
        first_row_c = IDX_W'(r);
      end
    end
    total_c      = 3'(acc_cnt_q) + hits_c;
    acc_cnt_d    = (total_c >= 3'd2) ? 2'd2 : total_c[1:0];
    acc_code_d   = (acc_cnt_q == 2'd0) ? pack_code(col_idx_w, first_row_c) : acc_code_q;
    res_c.single = (acc_cnt_d == 2'd1);
    res_c.code   = acc_code_d;
    dbc_inc_c    = dbc_ext_t'(dbc_q) + dbc_ext_t'(1);
    dbc_done_c   = (dbc_inc_c == DBC_TERM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt_q  <= '0;
      acc_code_q <= '0;
    end else if (sample_w) begin
      if (scan_end_w) begin
        acc_cnt_q  <= '0;
        acc_code_q <= '0;
      end else begin
        acc_cnt_q  <= acc_cnt_d;
        acc_code_q <= acc_code_d;
      end
    end
  end

  // Debounce FSM; it only moves on end-of-scan results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cand_q      <= '0;
      dbc_q       <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (scan_end_w) begin
        case (state_q)
          ST_IDLE: begin
            if (res_c.single) begin
              cand_q <= res_c.code;
              if (DEBOUNCE_SCANS == 1) begin
                key_q       <= res_c.code;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                dbc_q       <= '0;
                state_q     <= ST_PRESSED;
              end else begin
                dbc_q   <= DBC_W'(1);
                state_q <= ST_DEBOUNCE;
              end
            end
          end
          ST_DEBOUNCE: begin
            if (!res_c.single) begin
              dbc_q   <= '0;
              state_q <= ST_IDLE;
            end else if (res_c.code != cand_q) begin
              cand_q <= res_c.code;
              dbc_q  <= DBC_W'(1);
            end else if (dbc_done_c) begin
              key_q       <= cand_q;
              key_valid_q <= 1'b1;
              key_held_q  <= 1'b1;
              dbc_q       <= '0;
              state_q     <= ST_PRESSED;
            end else begin
              dbc_q <= dbc_inc_c[DBC_W-1:0];
            end
          end
          ST_PRESSED: begin
            if (res_c.single && (res_c.code == key_q)) begin
              dbc_q <= '0;
            end else if (DEBOUNCE_SCANS == 1) begin
              key_held_q <= 1'b0;
              dbc_q      <= '0;
              state_q    <= ST_IDLE;
            end else begin
              dbc_q   <= DBC_W'(1);
              state_q <= ST_RELEASE;
            end
          end
          ST_RELEASE: begin
            if (res_c.single && (res_c.code == key_q)) begin
              dbc_q   <= '0;
              state_q <= ST_PRESSED;
            end else if (dbc_done_c) begin
              key_held_q <= 1'b0;
              dbc_q      <= '0;
              state_q    <= ST_IDLE;
            end else begin
              dbc_q <= dbc_inc_c[DBC_W-1:0];
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign kp.col       = col_w;
  assign kp.key       = key_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the 7-segment display multiplexer: drives active-low column strobes to a 4x4 matrix keypad and reads the active-low rows back.
- Produces a debounced 4-bit key code with a one-cycle valid pulse, suitable as the data source for the display block.
- Uses the same dwell-counter scanning scheme as the display driver, applied in the receive direction.

Parameters:
- SCAN_MAX, 65000, dwell counter terminal value; each column is driven for SCAN_MAX+1 cycles.
- DEBOUNCE_SCANS, 4, number of consecutive full scans that must agree before a press or release is accepted (range 1..15).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- row  input  4  keypad rows, active-low (external pull-ups), asynchronous to clk
- col  output  4  column strobes, active-low, exactly one bit low at all times
- key  output  4  last accepted key code = {col_idx[1:0], row_idx[1:0]}
- key_valid  output  1  one-cycle pulse when a new press is accepted
- key_held  output  1  high while the accepted key remains pressed

Behaviour:
- Reset (asynchronous, immediate, including mid-scan or mid-debounce):
  - col=4'b1110, key=0, key_valid=0, key_held=0.
  - Dwell counter, column index, scan accumulators and debounce counter cleared to 0.
  - FSM forced to IDLE.
- Synchronizer: row passes through a 2-flop synchronizer (reset value 4'b1111); only the synchronized value is used.
- Dwell counter:
  - 16-bit; increments each cycle.
  - At cnt==SCAN_MAX: wraps to 0 and col rotates 1110→1101→1011→0111→1110, so col_idx goes 0,1,2,3,0.
- Sampling: synchronized rows are sampled on the cycle cnt==SCAN_MAX, before the column changes, which allows settling.
  - Row bit r low → key (col_idx, r) pressed.
  - Per-scan accumulator holds a press count (saturating at 2) and the code of the first press seen.
- Scan result: evaluated at the sample where col_idx==3, then the accumulator clears.
  - Count 0 → NONE.
  - Count 1 → SINGLE(code).
  - Count ≥2 → NONE (multi-key and ghosting rejected).
- FSM (advances only on scan-result events):
  - IDLE: SINGLE(c) → cand=c, dbc=1, go to DEBOUNCE; if DEBOUNCE_SCANS==1, accept immediately (see below).
  - DEBOUNCE:
    - SINGLE(cand): dbc++; when dbc==DEBOUNCE_SCANS, accept.
    - SINGLE(other): restart with cand=other, dbc=1.
    - NONE: return to IDLE.
  - Accept: key<=cand; key_valid pulses high for exactly one cycle (the cycle after the result event); key_held<=1; go to PRESSED.
  - PRESSED: SINGLE(key) → stay, dbc cleared. Anything else (NONE, a different key, multi-key) → go to RELEASE with dbc=1.
  - RELEASE:
    - Result not SINGLE(key): dbc++; when dbc==DEBOUNCE_SCANS, key_held<=0 and go to IDLE.
    - SINGLE(key): return to PRESSED, dbc=0.
  - A second key pressed while one is held produces no new key_valid until a full release and a new press.
- key retains the last accepted code after release; only reset clears it.
- Latency from a stable press to key_valid:
  - At most (DEBOUNCE_SCANS+1) full scans plus 3 cycles.
  - One full scan = 4*(SCAN_MAX+1) cycles.
- Pure function of the matrix: no auto-repeat while held.

Decomposition:
- Shared package: FSM state encoding (IDLE, DEBOUNCE, PRESSED, RELEASE), column one-hot reset constant 4'b1110, and the code packing {col_idx,row_idx}.
- One natural sub-module, scan_strobe: dwell counter plus column rotation plus sample-enable and end-of-scan strobes. The display driver can reuse the same scan_strobe.

Test Plan (SCAN_MAX=3, DEBOUNCE_SCANS=2; one full scan = 16 cycles):
- Reset then no keys, rows=1111 for 200 cycles → col cycles 1110,1101,1011,0111 at 4 cycles each; key_valid never asserts; key=0, key_held=0.
- Press (col 2, row 1): drive row[1] low whenever col==1011, held stable → exactly one key_valid pulse within 3 scans+3 cycles; key=4'b1001; key_held=1 until release.
- Release that key → key_held falls after 2 NONE scans; key stays 4'b1001; no further key_valid.
- Bounce: press (0,0) for one scan, release for one scan, repeat 5 times → no key_valid. Then hold → single pulse with key=4'b0000.
- Two keys (1,3) and (3,0) pressed together → no key_valid. Release (3,0) → pulse with key=4'b0111.
- Assert rst_n low mid-DEBOUNCE for 1 cycle → outputs immediately return to reset values, col=1110; no pulse is emitted for the interrupted press until it is re-debounced from scratch.
